usb_fs_capture: RTL and testbench

- Top-level FPGA block that captures one USB full-speed (12 Mb/s) packet from the D+/D- pins into an on-chip 1 KiB packet buffer.
- Clocked at 48 MHz, 4 samples per bit.
- Asserts the D+ pull-up to signal attach.
- Drives an RGB status LED.
- Does not transmit and does not interpret packet contents.

---
 rtl/usb_pkg.sv | 22 ++
 rtl/usb_line_rx.sv | 58 +++++
 rtl/usb_fs_capture.sv | 149 ++++++++++++++
 tb/tb_usb_fs_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the full-speed USB capture block.
package usb_pkg;

   typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;
   typedef enum logic [1:0] {IDLE, SYNC, DATA, DONE} cap_state_t;

   // Sync field K J K J K J K K, first bit in the MSB, K=0 and J=1
   localparam logic [7:0] SYNC_PATTERN     = 8'b01010100;
   localparam int         SAMPLES_PER_BIT  = 4;
   localparam int         BUFFER_BYTES     = 1024;
   localparam int         BUS_RESET_CYCLES = 120;

   function automatic line_state_t decode_line(input logic dp, input logic dn);
      case ({dp, dn})
         2'b10:   return J;
         2'b01:   return K;
         2'b00:   return SE0;
         default: return SE1;
      endcase
   endfunction

endpackage

// File: rtl/usb_line_rx.sv
// Pin synchroniser, line-state decode and mid-bit sampler for D+/D-.
module usb_line_rx #(
   parameter int SAMPLES_PER_BIT  = usb_pkg::SAMPLES_PER_BIT,
   parameter int BUS_RESET_CYCLES = usb_pkg::BUS_RESET_CYCLES
) (
   input  logic                  clock48,
   input  logic                  reset,
   input  logic                  usb_dp,
   input  logic                  usb_dn,
   output logic                  sample_valid,
   output usb_pkg::line_state_t  sample_state,
   output logic                  se0_long
);
   import usb_pkg::*;

   localparam int PW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
   localparam int CW = $clog2(BUS_RESET_CYCLES + 1);

   logic [1:0]    dp_sync;
   logic [1:0]    dn_sync;
   line_state_t   raw_state;
   line_state_t   cur_state;
   logic [PW-1:0] phase;
   logic [CW-1:0] se0_cnt;

   // SE1 is illegal on the bus; fold it into SE0 so downstream sees one state
   always_comb begin
      raw_state = decode_line(dp_sync[1], dn_sync[1]);
      if (raw_state == SE1) raw_state = SE0;
   end

   always_ff @(posedge clock48 or posedge reset) begin
      if (reset) begin
         dp_sync   <= '0;
         dn_sync   <= '0;
         cur_state <= SE0;
         phase     <= '0;
         se0_cnt   <= '0;
      end else begin
         dp_sync   <= {dp_sync[0], usb_dp};
         dn_sync   <= {dn_sync[0], usb_dn};
         cur_state <= raw_state;
         if (raw_state != cur_state || phase == PW'(SAMPLES_PER_BIT - 1))
            phase <= '0;
         else
            phase <= phase + 1'b1;
         if (raw_state != SE0)
            se0_cnt <= '0;
         else if (se0_cnt != CW'(BUS_RESET_CYCLES))
            se0_cnt <= se0_cnt + 1'b1;
      end
   end

   assign sample_valid = (phase == PW'(SAMPLES_PER_BIT / 2));
   assign sample_state = cur_state;
   assign se0_long     = (se0_cnt == CW'(BUS_RESET_CYCLES));

endmodule

// File: rtl/usb_fs_capture.sv
// Captures one raw full-speed USB packet into a word-organised byte buffer.
module usb_fs_capture #(
   parameter int BUFFER_BYTES     = usb_pkg::BUFFER_BYTES,
   parameter int SAMPLES_PER_BIT  = usb_pkg::SAMPLES_PER_BIT,
   parameter int BUS_RESET_CYCLES = usb_pkg::BUS_RESET_CYCLES
) (
   input  logic clock48,
   input  logic reset,
   input  logic usb_dp,
   input  logic usb_dn,
   output logic usb_pullup,
   output logic r,
   output logic g,
   output logic b
);
   import usb_pkg::*;

   localparam int WORDS = BUFFER_BYTES / 4;
   localparam int BCW   = $clog2(BUFFER_BYTES + 1);
   localparam int AW    = $clog2(BUFFER_BYTES);

   logic        sample_valid;
   logic        se0_long;
   line_state_t sample_state;

   cap_state_t     state;
   logic [2:0]     bit_cnt;
   logic [6:0]     shift;
   logic           se0_prev;
   logic [BCW-1:0] byte_count;
   logic           bus_reset_seen;
   logic           pkt_done;
   logic           busy;
   logic           wr_en;
   logic [AW-1:0]  wr_idx;
   logic [7:0]     wr_byte;
   logic           line_bit;
   logic           full;
   logic [7:0]     next_byte;

   logic [31:0] usb_packet_buffer [WORDS];

   usb_line_rx #(
      .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
      .BUS_RESET_CYCLES(BUS_RESET_CYCLES)
   ) u_line_rx (
      .clock48     (clock48),
      .reset       (reset),
      .usb_dp      (usb_dp),
      .usb_dn      (usb_dn),
      .sample_valid(sample_valid),
      .sample_state(sample_state),
      .se0_long    (se0_long)
   );

   // Raw line level, no NRZI decode; bytes assemble LSB-first
   assign line_bit  = (sample_state == J);
   assign next_byte = {line_bit, shift};
   assign full      = (byte_count == BCW'(BUFFER_BYTES));

   always_ff @(posedge clock48 or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         shift          <= '0;
         se0_prev       <= 1'b0;
         byte_count     <= '0;
         bus_reset_seen <= 1'b0;
         pkt_done       <= 1'b0;
         busy           <= 1'b0;
         wr_en          <= 1'b0;
         wr_idx         <= '0;
         wr_byte        <= '0;
         usb_pullup     <= 1'b0;
      end else begin
         usb_pullup <= 1'b1;
         wr_en      <= 1'b0;

         if (se0_long)
            bus_reset_seen <= 1'b1;
         else if (sample_state == J)
            bus_reset_seen <= 1'b0;

         if (se0_long) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else if (sample_valid) begin
            case (state)
               IDLE: begin
                  if (sample_state == K) begin
                     state   <= SYNC;
                     busy    <= 1'b1;
                     bit_cnt <= 3'd1;
                  end
               end
               SYNC: begin
                  if (sample_state == SE0 || line_bit != SYNC_PATTERN[3'd7 - bit_cnt]) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else if (bit_cnt == 3'd7) begin
                     state      <= DATA;
                     bit_cnt    <= '0;
                     byte_count <= '0;
                     pkt_done   <= 1'b0;
                     se0_prev   <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
               DATA: begin
                  if (sample_state == SE0) begin
                     se0_prev <= 1'b1;
                     if (se0_prev) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        pkt_done <= 1'b1;
                     end
                  end else begin
                     se0_prev <= 1'b0;
                     shift    <= next_byte[7:1];
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7 && !full) begin
                        wr_en      <= 1'b1;
                        wr_idx     <= AW'(byte_count);
                        wr_byte    <= next_byte;
                        byte_count <= byte_count + 1'b1;
                     end
                  end
               end
               DONE: begin
                  if (sample_state == J) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Buffer is deliberately not reset; only written bytes are meaningful
   always_ff @(posedge clock48) begin
      if (wr_en)
         usb_packet_buffer[wr_idx[AW-1:2]][{wr_idx[1:0], 3'b000} +: 8] <= wr_byte;
   end

   assign r = bus_reset_seen;
   assign g = pkt_done;
   assign b = busy;

endmodule

// File: tb/tb_usb_fs_capture.sv
// Bench for usb_fs_capture: packet vectors, write scoreboard and bus/reset corners.
`timescale 1ns/1ps
module tb_usb_fs_capture;
   import usb_pkg::*;

   logic clock48 = 1'b0;
   logic reset   = 1'b1;
   logic usb_dp  = 1'b1;
   logic usb_dn  = 1'b0;
   logic usb_pullup, r, g, b;

   usb_fs_capture dut (
      .clock48   (clock48),
      .reset     (reset),
      .usb_dp    (usb_dp),
      .usb_dn    (usb_dn),
      .usb_pullup(usb_pullup),
      .r         (r),
      .g         (g),
      .b         (b)
   );

   always #10.417 clock48 = ~clock48;

   typedef struct { int idx; logic [7:0] data; } wr_t;
   typedef struct {
      int          kind;
      int          nbytes;
      int          extra;
      logic [7:0]  sync;
      int          exp_count;
      logic        exp_g;
      logic [31:0] exp_w0;
   } vec_t;

   wr_t        sb[$];
   vec_t       vecs[6];
   int         checks = 0;
   int         failures = 0;
   logic [7:0] mem_model [1024];
   bit         mem_vld [1024];
   int         count_model = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every buffer write must match the next expected byte
   always @(negedge clock48) begin
      if (dut.wr_en) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: idx=%0d data=%h expected no write", dut.wr_idx, dut.wr_byte);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_idx", 32'(dut.wr_idx), e.idx);
            check("wr_byte", 32'(dut.wr_byte), 32'(e.data));
         end
      end
   end

   task automatic drive(input logic dp, input logic dn, input int cycles);
      usb_dp = dp;
      usb_dn = dn;
      repeat (cycles) @(negedge clock48);
   endtask

   task automatic send_bit(input logic v);
      drive(v, ~v, 4);
   endtask

   task automatic send_sync(input logic [7:0] pat);
      for (int i = 7; i >= 0; i--) send_bit(pat[i]);
      if (pat == SYNC_PATTERN) count_model = 0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      wr_t e;
      for (int i = 0; i < 8; i++) send_bit(v[i]);
      if (count_model < 1024) begin
         e.idx  = count_model;
         e.data = v;
         sb.push_back(e);
         mem_model[count_model] = v;
         mem_vld[count_model]   = 1'b1;
         count_model++;
      end
   endtask

   task automatic send_eop();
      drive(1'b0, 1'b0, 8);
      drive(1'b1, 1'b0, 40);
   endtask

   function automatic logic [7:0] pbyte(input int kind, input int i);
      case (kind)
         0: case (i)
               0: return 8'h48;
               1: return 8'h69;
               2: return 8'h21;
               default: return 8'h0A;
            endcase
         1: return 8'(i + 1);
         default: return 8'(i ^ ((i >> 8) * 32'h35));
      endcase
   endfunction

   task automatic check_buffer();
      for (int w = 0; w < 256; w++) begin
         logic [31:0] m, e;
         bit any;
         m = '0; e = '0; any = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (mem_vld[w*4+k]) begin
               m[k*8 +: 8] = 8'hFF;
               e[k*8 +: 8] = mem_model[w*4+k];
               any = 1'b1;
            end
         end
         if (any) check($sformatf("buf_word%0d", w), dut.usb_packet_buffer[w] & m, e);
      end
   endtask

   initial begin
      vecs[0] = '{0, 4,    0, SYNC_PATTERN, 4,    1'b1, 32'h0A216948};
      vecs[1] = '{1, 5,    3, SYNC_PATTERN, 5,    1'b1, 32'h04030201};
      vecs[2] = '{1, 0,    0, 8'b01011100,  5,    1'b1, 32'h04030201};
      vecs[3] = '{2, 1030, 0, SYNC_PATTERN, 1024, 1'b1, 32'h03020100};
      vecs[4] = '{1, 2,    7, SYNC_PATTERN, 2,    1'b1, 32'h03020201};
      vecs[5] = '{1, 0,    0, SYNC_PATTERN, 0,    1'b1, 32'h03020201};
      for (int i = 0; i < 1024; i++) mem_vld[i] = 1'b0;

      // Reset state and pull-up timing
      repeat (3) @(negedge clock48);
      check("rst_pullup", 32'(usb_pullup), 0);
      check("rst_rgb", 32'({r, g, b}), 0);
      check("rst_byte_count", 32'(dut.byte_count), 0);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      reset = 1'b0;
      #1 check("pullup_before_edge", 32'(usb_pullup), 0);
      @(posedge clock48);
      #1 check("pullup_after_edge", 32'(usb_pullup), 1);
      @(negedge clock48);
      drive(1'b1, 1'b0, 20);

      // Bus reset while idle, then SE1 which must behave like SE0
      drive(1'b0, 1'b0, 200);
      check("busrst_r", 32'(r), 1);
      check("busrst_state", 32'(dut.state), 32'(IDLE));
      drive(1'b1, 1'b0, 20);
      check("busrst_r_clear", 32'(r), 0);
      drive(1'b1, 1'b1, 200);
      check("se1_busrst_r", 32'(r), 1);
      drive(1'b1, 1'b0, 20);
      check("se1_r_clear", 32'(r), 0);

      foreach (vecs[v]) begin
         send_sync(vecs[v].sync);
         if (vecs[v].sync == SYNC_PATTERN) begin
            for (int i = 0; i < vecs[v].nbytes; i++) send_byte(pbyte(vecs[v].kind, i));
            for (int i = 0; i < vecs[v].extra; i++) send_bit(1'($urandom_range(0, 1)));
            send_eop();
         end else begin
            drive(1'b1, 1'b0, 40);
         end
         check($sformatf("v%0d_byte_count", v), 32'(dut.byte_count), vecs[v].exp_count);
         check($sformatf("v%0d_g", v), 32'(g), 32'(vecs[v].exp_g));
         check($sformatf("v%0d_b", v), 32'(b), 0);
         check($sformatf("v%0d_r", v), 32'(r), 0);
         check($sformatf("v%0d_state", v), 32'(dut.state), 32'(IDLE));
         check($sformatf("v%0d_word0", v), dut.usb_packet_buffer[0], vecs[v].exp_w0);
         check($sformatf("v%0d_sb_drained", v), sb.size(), 0);
         check_buffer();
      end

      // Bus reset in the middle of a packet keeps bytes already written
      send_sync(SYNC_PATTERN);
      send_byte(8'hA5);
      send_byte(8'h5A);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      check("midpkt_b", 32'(b), 1);
      drive(1'b0, 1'b0, 200);
      check("midpkt_busrst_r", 32'(r), 1);
      check("midpkt_busrst_state", 32'(dut.state), 32'(IDLE));
      check("midpkt_busrst_count", 32'(dut.byte_count), 2);
      check("midpkt_busrst_b", 32'(b), 0);
      drive(1'b1, 1'b0, 20);
      check("midpkt_r_clear", 32'(r), 0);
      check("midpkt_sb_drained", sb.size(), 0);

      // Async reset in the middle of a packet
      send_sync(SYNC_PATTERN);
      send_byte(8'h11);
      send_byte(8'h22);
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      check("pre_reset_b", 32'(b), 1);
      check("pre_reset_count", 32'(dut.byte_count), 2);
      reset = 1'b1;
      #1;
      check("mid_reset_count", 32'(dut.byte_count), 0);
      check("mid_reset_pullup", 32'(usb_pullup), 0);
      check("mid_reset_rgb", 32'({r, g, b}), 0);
      check("mid_reset_state", 32'(dut.state), 32'(IDLE));
      count_model = 0;
      usb_dp = 1'b1;
      usb_dn = 1'b0;
      @(negedge clock48);
      reset = 1'b0;
      repeat (3) @(negedge clock48);
      check("post_reset_pullup", 32'(usb_pullup), 1);
      check("post_reset_sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
